mul_div_unit: RTL and testbench
===============================

# mul_div_unit

Multi-cycle multiply/divide unit with architectural HI/LO registers, located in the EX stage directly downstream of the EX control decoder. It consumes the decoder's 2-bit MULOp together with the two forwarded operands, runs MULT/MULTU in a fixed-latency pipeline and DIV/DIVU in an iterative restoring divider, and updates HI/LO on completion. The pipeline hazard unit uses Busy|Start to stall MFHI/MFLO/MTHI/MTLO and further mul/div issue.

## Interface
- MUL_LAT, 5, Busy cycles for MULT/MULTU; legal range 1..15.
- DIV_ITER, 32, divider iteration cycles; fixed at 32 for 32-bit operands.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- Start  in  1  issue strobe; sampled only when idle.
- MULOp  in  2  operation: 00 mult signed, 01 multu, 10 div signed, 11 divu. Ignored (may be z) when Start=0.
- D1  in  32  rs operand (multiplicand/dividend).
- D2  in  32  rt operand (multiplier/divisor).
- HIWrite  in  1  MTHI: write WD to HI.
- LOWrite  in  1  MTLO: write WD to LO.
- WD  in  32  MTHI/MTLO data.
- Busy  out  1  operation in flight.
- HI  out  32  HI register.
- LO  out  32  LO register.

## Operation
- States: IDLE, MUL, DIV, FIX. Busy = (state != IDLE), registered.
- IDLE, Start=1, MULOp[1]=0: register 64-bit product (signed or unsigned per MULOp[0]), load counter MUL_LAT-1, go MUL.
- MUL: counter decrements; at 0 write HI=product[63:32], LO=product[31:0], go IDLE.
- IDLE, Start=1, MULOp[1]=1: latch |D1|, |D2| (signed) or raw (unsigned), latch quotient/remainder sign flags and divide-by-zero flag, go DIV.
- DIV: one restoring shift-subtract step per cycle for DIV_ITER cycles, then FIX.
- FIX: signed quotient negated if sign(D1)^sign(D2); remainder takes sign of D1. Write LO=quotient, HI=remainder, go IDLE.
- Divide by zero: full latency, HI and LO unchanged.
- 0x80000000 div 0xFFFFFFFF (signed): LO=0x80000000, HI=0 (two's-complement wrap).
- Start while Busy: ignored. HIWrite/LOWrite while Busy: ignored.
- Start and HIWrite/LOWrite same idle cycle: Start wins, write dropped.
- HIWrite and LOWrite together: both registers written.
- Reset: async, any state → IDLE, HI=0, LO=0, Busy=0, counter=0, in-flight operation discarded.

## Timing
- Start sampled at edge E0. Busy high from E0 through completion.
- MULT/MULTU: Busy high for MUL_LAT cycles; HI/LO updated at edge E0+MUL_LAT, Busy low in the same cycle.
- DIV/DIVU: Busy high for DIV_ITER+1 = 33 cycles; HI/LO updated at edge E0+33.
- A new Start is accepted in the first cycle Busy is low (back-to-back issue, no bubble).
- MTHI/MTLO: HI/LO updated at the sampling edge; visible next cycle.
- HI/LO are direct register outputs, with no combinational path from inputs.

## Structure
- Shared header: MULOp encodings (MUL_S, MUL_U, DIV_S, DIV_U), state encodings, default MUL_LAT/DIV_ITER, alongside the existing opcode/macro headers.
- Sub-module div_core: 32-step restoring unsigned divider (load, step, done; outputs quotient and remainder). Sign handling, FIX and HI/LO writes stay in mul_div_unit.

## Test plan
- mult D1=0xFFFFFFFE (−2), D2=3 → Busy for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA. multu with the same operands → HI=0x00000002, LO=0xFFFFFFFA.
- div D1=−7 (0xFFFFFFF9), D2=2 → after 33 Busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 7/2 → LO=3, HI=1.
- divu D2=0 with HI=0x11, LO=0x22 preset via MTHI/MTLO → 33 Busy cycles, HI=0x11, LO=0x22 unchanged.
- Start pulsed again mid-divide with different operands, plus LOWrite while Busy → both ignored; the original result is written. Start on the cycle Busy drops → accepted.
- rst_n asserted mid-multiply (cycle 3) → Busy=0, HI=LO=0 immediately. After release, a new mult of 6×7 gives LO=42 after 5 cycles.

Source files
------------

// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit.
package mul_div_unit_pkg;

  // MULOp encodings as produced by the EX control decoder
  typedef enum logic [1:0] {
    MUL_S = 2'b00,
    MUL_U = 2'b01,
    DIV_S = 2'b10,
    DIV_U = 2'b11
  } mulop_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX
  } state_e;

  localparam int unsigned XLEN         = 32;
  localparam int unsigned MUL_LAT_DEF  = 5;
  localparam int unsigned DIV_ITER_DEF = 32;
  // wide enough for DIV_ITER-1 (31) and MUL_LAT-1 (<= 14)
  localparam int unsigned CNT_W        = 5;

endpackage

// File: rtl/mul_div_unit_if.sv
// Issue/result bundle between the EX decoder side and the mul/div unit.
interface mul_div_unit_if;
  logic        Start;
  logic [1:0]  MULOp;
  logic [31:0] D1;
  logic [31:0] D2;
  logic        HIWrite;
  logic        LOWrite;
  logic [31:0] WD;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output Start, MULOp, D1, D2, HIWrite, LOWrite, WD,
    input  Busy, HI, LO
  );

  modport slave (
    input  Start, MULOp, D1, D2, HIWrite, LOWrite, WD,
    output Busy, HI, LO
  );
endinterface

// File: rtl/mul_div_unit_div_core.sv
// Restoring unsigned divider: load latches operands, each step retires one quotient bit.
module div_core #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         step,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
);

  logic [W-1:0] rem_q, rem_d;
  logic [W-1:0] quo_q, quo_d;
  logic [W-1:0] dvs_q, dvs_d;
  logic [W:0]   shifted;
  logic [W:0]   diff;

  // shift-subtract step; a borrow in diff[W] means the trial subtraction is restored
  always_comb begin
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    shifted = {rem_q, quo_q[W-1]};
    diff    = shifted - {1'b0, dvs_q};
    if (load) begin
      rem_d = '0;
      quo_d = dividend;
      dvs_d = divisor;
    end else if (step) begin
      if (!diff[W]) begin
        rem_d = diff[W-1:0];
        quo_d = {quo_q[W-2:0], 1'b1};
      end else begin
        rem_d = shifted[W-1:0];
        quo_d = {quo_q[W-2:0], 1'b0};
      end
    end
  end

  // divider datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int unsigned MUL_LAT  = MUL_LAT_DEF,
  parameter int unsigned DIV_ITER = DIV_ITER_DEF
) (
  input logic           clk,
  input logic           rst_n,
  mul_div_unit_if.slave bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      prod_q, prod_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             dz_q, dz_d;
  logic             busy_q, busy_d;

  logic             op_signed;
  logic [63:0]      mul_a, mul_b;
  logic [31:0]      dvd_abs, dvs_abs;
  logic             div_load, div_step;
  logic [31:0]      div_quo, div_rem;

  // operand conditioning: one 64-bit multiplier serves both signednesses via extension
  always_comb begin
    op_signed = ~bus.MULOp[0];
    mul_a     = {{32{op_signed & bus.D1[31]}}, bus.D1};
    mul_b     = {{32{op_signed & bus.D2[31]}}, bus.D2};
    dvd_abs   = (op_signed && bus.D1[31]) ? -bus.D1 : bus.D1;
    dvs_abs   = (op_signed && bus.D2[31]) ? -bus.D2 : bus.D2;
  end

  // next-state, counter, HI/LO update and divider control
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    div_load = 1'b0;
    div_step = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.Start) begin
          if (!bus.MULOp[1]) begin
            prod_d  = mul_a * mul_b;
            cnt_d   = CNT_W'(MUL_LAT - 1);
            state_d = ST_MUL;
          end else begin
            div_load = 1'b1;
            qneg_d   = op_signed & (bus.D1[31] ^ bus.D2[31]);
            rneg_d   = op_signed & bus.D1[31];
            dz_d     = (bus.D2 == '0);
            cnt_d    = CNT_W'(DIV_ITER - 1);
            state_d  = ST_DIV;
          end
        end else begin
          if (bus.HIWrite) hi_d = bus.WD;
          if (bus.LOWrite) lo_d = bus.WD;
        end
      end
      ST_MUL: begin
        if (cnt_q == '0) begin
          hi_d    = prod_q[63:32];
          lo_d    = prod_q[31:0];
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DIV: begin
        div_step = 1'b1;
        if (cnt_q == '0) state_d = ST_FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_FIX: begin
        if (!dz_q) begin
          lo_d = qneg_q ? -div_quo : div_quo;
          hi_d = rneg_q ? -div_rem : div_rem;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // state and architectural registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      prod_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      busy_q  <= busy_d;
    end
  end

  div_core #(.W(XLEN)) u_div_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (div_load),
    .step      (div_step),
    .dividend  (dvd_abs),
    .divisor   (dvs_abs),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  assign bus.Busy = busy_q;
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit against an arithmetic reference model.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  localparam int unsigned P_MUL_LAT  = 5;
  localparam int unsigned P_DIV_ITER = 32;

  logic clk;
  logic rst_n;
  mul_div_unit_if bus ();

  int vectors;
  int miscompares;
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  mul_div_unit #(.MUL_LAT(P_MUL_LAT), .DIV_ITER(P_DIV_ITER)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // reference: plain integer arithmetic on the architectural operation
  function automatic void model(input mulop_e op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, sq, sr;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      MUL_S: begin
        p = 64'(sa * sb);
        exp_hi = p[63:32];
        exp_lo = p[31:0];
      end
      MUL_U: begin
        p = 64'(a) * 64'(b);
        exp_hi = p[63:32];
        exp_lo = p[31:0];
      end
      DIV_S: if (b != 0) begin
        sq = sa / sb;
        sr = sa % sb;
        exp_lo = 32'(sq);
        exp_hi = 32'(sr);
      end
      default: if (b != 0) begin
        exp_lo = a / b;
        exp_hi = a % b;
      end
    endcase
  endfunction

  task automatic idle_inputs();
    bus.Start   = 1'b0;
    bus.MULOp   = 2'bzz;
    bus.D1      = $urandom;
    bus.D2      = $urandom;
    bus.HIWrite = 1'b0;
    bus.LOWrite = 1'b0;
    bus.WD      = $urandom;
  endtask

  // issue one op, optionally disturbing it mid-flight, then check latency and HI/LO
  task automatic run_op(input mulop_e op, input logic [31:0] a, input logic [31:0] b,
                        input bit disturb, input bit mt_with_start);
    int n;
    int lat;
    bus.Start = 1'b1;
    bus.MULOp = op;
    bus.D1    = a;
    bus.D2    = b;
    if (mt_with_start) begin
      bus.HIWrite = 1'b1;
      bus.LOWrite = 1'b1;
      bus.WD      = 32'hDEAD_BEEF;
    end
    tick();
    idle_inputs();
    check("busy_after_start", bus.Busy, 1);
    n = 0;
    while (bus.Busy && n < 100) begin
      if (disturb && n == 3) begin
        bus.Start   = 1'b1;
        bus.MULOp   = 2'($urandom_range(0, 3));
        bus.LOWrite = 1'b1;
        bus.HIWrite = 1'b1;
        bus.WD      = 32'hBAD0_BAD0;
      end
      tick();
      idle_inputs();
      n++;
    end
    lat = (op == DIV_S || op == DIV_U) ? int'(P_DIV_ITER) + 1 : int'(P_MUL_LAT);
    model(op, a, b);
    check("busy_cycles", 64'(n), 64'(lat));
    check("hi", bus.HI, exp_hi);
    check("lo", bus.LO, exp_lo);
  endtask

  task automatic mt(input bit hw, input bit lw, input logic [31:0] wd);
    bus.HIWrite = hw;
    bus.LOWrite = lw;
    bus.WD      = wd;
    tick();
    idle_inputs();
    if (hw) exp_hi = wd;
    if (lw) exp_lo = wd;
    check("mt_hi", bus.HI, exp_hi);
    check("mt_lo", bus.LO, exp_lo);
  endtask

  initial begin
    mulop_e      op;
    logic [31:0] a, b;
    vectors     = 0;
    miscompares = 0;
    exp_hi      = '0;
    exp_lo      = '0;
    rst_n       = 1'b0;
    idle_inputs();
    #2;
    check("reset_busy", bus.Busy, 0);
    check("reset_hi", bus.HI, 0);
    check("reset_lo", bus.LO, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // directed arithmetic cases
    run_op(MUL_S, 32'hFFFF_FFFE, 32'd3, 0, 0);
    check("mult_hi_const", bus.HI, 32'hFFFF_FFFF);
    check("mult_lo_const", bus.LO, 32'hFFFF_FFFA);
    run_op(MUL_U, 32'hFFFF_FFFE, 32'd3, 0, 0);
    check("multu_hi_const", bus.HI, 32'h0000_0002);
    run_op(DIV_S, 32'hFFFF_FFF9, 32'd2, 0, 0);
    check("div_lo_const", bus.LO, 32'hFFFF_FFFD);
    check("div_hi_const", bus.HI, 32'hFFFF_FFFF);
    run_op(DIV_U, 32'd7, 32'd2, 0, 0);
    run_op(DIV_S, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    check("ovf_lo_const", bus.LO, 32'h8000_0000);

    // MTHI/MTLO, then divide by zero leaves them intact
    mt(1, 0, 32'h11);
    mt(0, 1, 32'h22);
    run_op(DIV_U, 32'd1234, 32'd0, 0, 0);
    check("dz_hi_const", bus.HI, 32'h11);
    check("dz_lo_const", bus.LO, 32'h22);
    run_op(DIV_S, 32'hFFFF_0000, 32'd0, 0, 0);
    mt(1, 1, 32'h5A5A_A5A5);

    // Start with MTHI/MTLO in the same idle cycle: write is dropped
    run_op(DIV_U, 32'd99, 32'd0, 0, 1);

    // mid-divide Start and MTLO ignored, then back-to-back issue
    run_op(DIV_U, 32'd100, 32'd7, 1, 0);
    run_op(MUL_S, 32'h8000_0000, 32'h8000_0000, 1, 0);
    run_op(DIV_S, 32'd100, 32'hFFFF_FFF9, 0, 0);

    // reset in the middle of a multiply
    bus.Start = 1'b1;
    bus.MULOp = MUL_U;
    bus.D1    = 32'h1234_5678;
    bus.D2    = 32'h9ABC_DEF0;
    tick();
    idle_inputs();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    exp_hi = '0;
    exp_lo = '0;
    check("midreset_busy", bus.Busy, 0);
    check("midreset_hi", bus.HI, 0);
    check("midreset_lo", bus.LO, 0);
    tick();
    rst_n = 1'b1;
    tick();
    run_op(MUL_S, 32'd6, 32'd7, 0, 0);
    check("six_by_seven", bus.LO, 32'd42);

    // randomized mix of ops and register moves
    for (int i = 0; i < 40; i++) begin
      op = mulop_e'($urandom_range(0, 3));
      a  = $urandom;
      case ($urandom_range(0, 4))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 20));
        2:       b = -32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      if ($urandom_range(0, 5) == 0)
        mt(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      run_op(op, a, b, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 5) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
